// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 pipeline controller: EX op codes,
// stall vector encodings and the multi-cycle FSM state type.
package mips_pkg;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_MADD = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;

  // Stall bits: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_MULTI = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Request/response bundle between the pipeline stages and the stall/flush
// controller; the controller uses the slave modport.
interface pipeline_ctrl_if;

  logic        stallreq_id_i;
  logic        ex_valid_i;
  logic [1:0]  ex_op_i;
  logic        flush_req_i;
  logic [31:0] exc_vector_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        ex_busy_o;
  logic        ex_done_o;

  modport master (
    output stallreq_id_i, ex_valid_i, ex_op_i, flush_req_i, exc_vector_i,
    input  stall_o, flush_o, new_pc_o, ex_busy_o, ex_done_o
  );

  modport slave (
    input  stallreq_id_i, ex_valid_i, ex_op_i, flush_req_i, exc_vector_i,
    output stall_o, flush_o, new_pc_o, ex_busy_o, ex_done_o
  );

endinterface

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the five-stage pipeline; holds EX for a
// fixed number of cycles per multi-cycle op and arbitrates flush/stall.
module pipeline_ctrl
  import mips_pkg::*;
#(
  parameter int MADD_CYCLES = 2,
  parameter int DIV_CYCLES  = 34,
  parameter int CNT_W       = 6
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       op_q, op_d;

  logic        multi_req;
  logic        ex_stall;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        busy;
  logic        done;

  assign multi_req = bus.ex_valid_i &&
                     ((bus.ex_op_i == OP_MADD) || (bus.ex_op_i == OP_DIV));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_q  <= OP_NONE;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      op_q  <= op_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    op_d     = op_q;
    ex_stall = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    stall    = STALL_NONE;
    flush    = 1'b0;
    new_pc   = '0;

    case (state)
      ST_IDLE: begin
        if (multi_req) begin
          op_d     = bus.ex_op_i;
          cnt_d    = (bus.ex_op_i == OP_MADD) ? CNT_W'(MADD_CYCLES - 1)
                                              : CNT_W'(DIV_CYCLES - 1);
          state_d  = ST_MULTI;
          ex_stall = 1'b1;
          busy     = 1'b1;
        end
      end
      ST_MULTI: begin
        // op_q alone governs the hold; new EX inputs are ignored here
        ex_stall = (op_q != OP_NONE);
        busy     = 1'b1;
        if (cnt == CNT_W'(1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        busy    = 1'b1;
        op_d    = OP_NONE;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        op_d    = OP_NONE;
      end
    endcase

    if (ex_stall)
      stall = STALL_EX;
    else if (bus.stallreq_id_i)
      stall = STALL_ID;

    // An exception flush aborts any in-flight multi-cycle op
    if (bus.flush_req_i) begin
      flush   = 1'b1;
      stall   = STALL_NONE;
      new_pc  = bus.exc_vector_i;
      done    = 1'b0;
      state_d = ST_IDLE;
      cnt_d   = '0;
      op_d    = OP_NONE;
    end
  end

  // Outputs are combinational, so they must be forced quiet during reset
  always_comb begin
    bus.stall_o   = rst ? STALL_NONE : stall;
    bus.flush_o   = rst ? 1'b0 : flush;
    bus.new_pc_o  = rst ? 32'd0 : new_pc;
    bus.ex_busy_o = rst ? 1'b0 : busy;
    bus.ex_done_o = rst ? 1'b0 : done;
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed hazard scenarios followed by
// random traffic, checked against a stall-count reference model.
module tb_pipeline_ctrl;

  localparam int MADD_N = 2;
  localparam int DIV_N  = 34;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        busy;
    logic        done;
  } expect_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipeline_ctrl_if bus();

  pipeline_ctrl #(
    .MADD_CYCLES(MADD_N),
    .DIV_CYCLES (DIV_N),
    .CNT_W      (6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  expect_t sbq[$];
  int      checkCount = 0;
  int      errCount   = 0;
  int      cycleNo    = 0;

  // Reference model: remaining EX stall cycles and a pending-done flag
  int      mRem  = 0;
  logic    mDone = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected, input int cyc);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic sreq, input logic v,
                               input logic [1:0] op, input logic fl,
                               input logic [31:0] vec);
    expect_t e;
    logic    req, exStall;
    @(posedge clk);
    #1;
    rst                  = r;
    bus.stallreq_id_i    = sreq;
    bus.ex_valid_i       = v;
    bus.ex_op_i          = op;
    bus.flush_req_i      = fl;
    bus.exc_vector_i     = vec;
    cycleNo++;
    req = v && (op == 2'b01 || op == 2'b10);
    e   = '0;
    if (r) begin
      mRem  = 0;
      mDone = 1'b0;
    end else begin
      exStall = 1'b0;
      if (mDone) begin
        exStall = 1'b0;
      end else if (mRem > 0) begin
        exStall = 1'b1;
      end else if (req) begin
        exStall = 1'b1;
        mRem    = (op == 2'b01) ? MADD_N : DIV_N;
      end
      e.busy   = (mRem > 0) || mDone || req;
      e.flush  = fl;
      e.new_pc = fl ? vec : 32'd0;
      e.stall  = fl ? 6'b000000 : exStall ? 6'b001111 : sreq ? 6'b000111 : 6'b000000;
      e.done   = mDone && !fl;
      if (fl) begin
        mRem  = 0;
        mDone = 1'b0;
      end else if (mDone) begin
        mDone = 1'b0;
      end else if (exStall) begin
        mRem--;
        if (mRem == 0) mDone = 1'b1;
      end
    end
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    expect_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checkOutput("stall_o",   32'(bus.stall_o),   32'(e.stall),  cycleNo);
      checkOutput("flush_o",   32'(bus.flush_o),   32'(e.flush),  cycleNo);
      checkOutput("new_pc_o",  bus.new_pc_o,       e.new_pc,      cycleNo);
      checkOutput("ex_busy_o", 32'(bus.ex_busy_o), 32'(e.busy),   cycleNo);
      checkOutput("ex_done_o", 32'(bus.ex_done_o), 32'(e.done),   cycleNo);
    end
  end

  initial begin
    bus.stallreq_id_i = 1'b0;
    bus.ex_valid_i    = 1'b0;
    bus.ex_op_i       = 2'b00;
    bus.flush_req_i   = 1'b0;
    bus.exc_vector_i  = 32'd0;

    $display("[TB] reset with hazard inputs toggling");
    applyStimulus(1, 1, 0, 2'b00, 1, 32'h1234_5678);
    applyStimulus(1, 0, 1, 2'b10, 0, 32'd0);
    applyStimulus(1, 1, 0, 2'b00, 1, 32'hDEAD_BEEF);
    applyStimulus(0, 0, 0, 2'b00, 0, 32'd0);

    $display("[TB] load-use stall");
    applyStimulus(0, 1, 0, 2'b00, 0, 32'd0);
    applyStimulus(0, 0, 0, 2'b00, 0, 32'd0);

    $display("[TB] divide then madd");
    for (int i = 0; i < DIV_N + 1; i++) applyStimulus(0, 0, 1, 2'b10, 0, 32'd0);
    applyStimulus(0, 0, 0, 2'b00, 0, 32'd0);
    for (int i = 0; i < MADD_N + 1; i++) applyStimulus(0, 0, 1, 2'b01, 0, 32'd0);
    applyStimulus(0, 0, 0, 2'b00, 0, 32'd0);

    $display("[TB] load-use during madd");
    for (int i = 0; i < MADD_N + 1; i++) applyStimulus(0, 1, 1, 2'b01, 0, 32'd0);
    applyStimulus(0, 0, 0, 2'b00, 0, 32'd0);

    $display("[TB] flush mid-divide");
    for (int i = 0; i < 9; i++) applyStimulus(0, 0, 1, 2'b10, 0, 32'd0);
    applyStimulus(0, 0, 1, 2'b10, 1, 32'hBFC0_0380);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 2'b00, 0, 32'd0);
    for (int i = 0; i < DIV_N + 1; i++) applyStimulus(0, 0, 1, 2'b10, 0, 32'd0);

    $display("[TB] flush on done cycle");
    for (int i = 0; i < MADD_N; i++) applyStimulus(0, 0, 1, 2'b01, 0, 32'd0);
    applyStimulus(0, 0, 0, 2'b00, 1, 32'h8000_0180);

    $display("[TB] back-to-back madd and div");
    for (int i = 0; i < MADD_N + 1; i++) applyStimulus(0, 0, 1, 2'b01, 0, 32'd0);
    for (int i = 0; i < DIV_N + 1; i++) applyStimulus(0, 0, 1, 2'b10, 0, 32'd0);
    applyStimulus(0, 0, 0, 2'b00, 0, 32'd0);

    $display("[TB] reset mid-multi and reserved op");
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 2'b10, 0, 32'd0);
    applyStimulus(1, 0, 0, 2'b00, 0, 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 2'b00, 0, 32'd0);
    applyStimulus(0, 1, 1, 2'b11, 0, 32'd0);
    applyStimulus(0, 0, 0, 2'b10, 0, 32'd0);
    applyStimulus(0, 0, 0, 2'b01, 0, 32'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(149) == 0),
                    ($urandom_range(3) == 0),
                    ($urandom_range(2) == 0),
                    2'($urandom_range(3)),
                    ($urandom_range(39) == 0),
                    $urandom());
    end

    repeat (2) @(posedge clk);
    checkOutput("scoreboard_drain", 32'(sbq.size()), 32'd0, cycleNo);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush controller for the five-stage MIPS32 pipeline: PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Combines the ID-stage load-use stall request, multi-cycle EX operations (multiply-accumulate, iterative divide) and MEM-stage exception flushes.
- Produces one stall vector and one flush pulse, which every pipeline register and the PC consume.
- Contains an FSM with a cycle counter that holds the EX stage for a fixed, parameterised number of cycles per multi-cycle operation.

Parameters:
MADD_CYCLES, 2, total stall cycles for madd/msub (must be >= 2)
DIV_CYCLES, 34, total stall cycles for div/divu (must be >= 2)
CNT_W, 6, counter width; must hold max(MADD_CYCLES, DIV_CYCLES)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
stallreq_id_i  input  1  load-use hazard detected in ID
ex_valid_i  input  1  EX holds a valid instruction
ex_op_i  input  2  00 none, 01 madd, 10 div, 11 reserved (treated as none)
flush_req_i  input  1  exception/eret taken in MEM
exc_vector_i  input  32  redirect target for flush
stall_o  output  6  [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB; 1 = hold
flush_o  output  1  clear all pipeline registers this cycle
new_pc_o  output  32  PC redirect, valid when flush_o=1
ex_busy_o  output  1  multi-cycle op in progress
ex_done_o  output  1  one-cycle pulse: multi-cycle result valid, EX released

Behaviour:
Clock and reset
- One clock domain (clk). rst is asynchronous, active-high.
- On reset: state=IDLE, cnt=0, op_q=00.
- While rst=1: stall_o=6'b000000, flush_o=0, new_pc_o=0, ex_busy_o=0, ex_done_o=0.

Output timing
- All outputs are combinational from the current state and inputs. There is no added latency; a request is honoured in the cycle it is asserted.

FSM states: IDLE, MULTI, DONE
- IDLE, with ex_valid_i=1 and ex_op_i in {01,10}:
  - latch op_q
  - cnt <= N-1, where N = MADD_CYCLES or DIV_CYCLES
  - go to MULTI
  - assert EX stall in this same cycle
- MULTI: assert EX stall. If cnt==1, go to DONE; otherwise cnt <= cnt-1.
- DONE:
  - ex_done_o=1; no EX stall, so the EX/MEM register captures the result
  - return to IDLE
  - the same EX instruction is not re-accepted
- Total EX stall cycles per op = N exactly. ex_done_o fires in cycle N+1, counting the request cycle as cycle 1.
- ex_op_i and ex_valid_i changes while in MULTI or DONE are ignored; op_q governs.
- ex_busy_o = (state != IDLE) or (IDLE and a multi-cycle request is present).

Stall encoding and priority (highest first)
1. flush_req_i=1:
   - flush_o=1, stall_o=0, new_pc_o=exc_vector_i
   - next state IDLE, cnt=0, ex_done_o=0 (the in-flight op is aborted)
2. EX stall (IDLE with request, or MULTI): stall_o=6'b001111, whatever stallreq_id_i is.
3. stallreq_id_i=1: stall_o=6'b000111.
4. Otherwise stall_o=0.
- flush_o=0 whenever flush_req_i=0. new_pc_o=0 when flush_o=0.

Boundary conditions
- Reset asserted mid-MULTI: immediate return to IDLE; no ex_done_o pulse.
- Flush coinciding with the DONE cycle: flush wins and ex_done_o=0.
- Back-to-back multi-cycle ops: after DONE, IDLE may accept the next op in the very next cycle.
- ex_op_i=11 or ex_valid_i=0: no multi-cycle activity.

Decomposition:
Shared package mips_pkg:
- op codes OP_NONE/OP_MADD/OP_DIV
- stall vector constants STALL_NONE=000000, STALL_ID=000111, STALL_EX=001111
- FSM state enum
No sub-module; the counter and FSM stay in one module.

Test Plan:
1. Reset: hold rst=1 for 3 cycles, pulse stallreq_id_i and flush_req_i -> every output stays 0. Release rst -> state IDLE.
2. Load-use: stallreq_id_i=1 for 1 cycle, no EX op -> stall_o=000111 for exactly that cycle, flush_o=0.
3. Divide, DIV_CYCLES=34: ex_valid_i=1, ex_op_i=10 -> stall_o=001111 for 34 cycles; ex_done_o=1 in cycle 35 with stall_o=0; ex_busy_o high for cycles 1-35. Repeat with madd: 2 stall cycles, done in cycle 3.
4. Simultaneous stalls: stallreq_id_i=1 throughout a madd -> stall_o=001111 during the stall, then 000111 in the DONE cycle.
5. Flush mid-divide: flush_req_i=1 in cycle 10 with exc_vector_i=32'hBFC00380 -> flush_o=1, new_pc_o=BFC00380, stall_o=0 in that cycle; no ex_done_o afterwards; the next divide request is accepted.
6. Back-to-back ops: madd then div with no gap -> done pulses in cycles 3 and 38; the EX stall is released only in cycle 3.
